// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the instruction memory path: the bus word type,
// the responder FSM state encoding and the position of the word index in a
// byte address.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      READY = 2'd2
   } imem_state_t;

   // Byte addresses are word aligned; bits below this position are ignored.
   localparam int IMEM_IDX_LSB = 2;

endpackage

// File: rtl/i_mem_responder_if.sv
// Instruction fetch request/response plus the program-load write port.
// Handshake: the requester holds iREN high with a stable iaddr; the word on
// iload is taken in the cycle where iREN=1 and iwait=0. Dropping iREN or
// changing the word index before then abandons the request. pWEN writes
// pstore to the word at paddr on the clock edge, with no back-pressure.
interface i_mem_responder_if;
   import cpu_types_pkg::*;

   logic  iREN;
   word_t iaddr;
   logic  iwait;
   word_t iload;
   logic  pWEN;
   word_t paddr;
   word_t pstore;

   modport master (
      output iREN, iaddr, pWEN, paddr, pstore,
      input  iwait, iload
   );

   modport slave (
      input  iREN, iaddr, pWEN, paddr, pstore,
      output iwait, iload
   );

endinterface

// File: rtl/imem_array.sv
// Word store behind the instruction responder: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module imem_array
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  word_t            wdata,
   input  logic [IDX_W-1:0] ridx,
   output word_t            rdata
);

   word_t mem [DEPTH];

   // Program-load writes land on the clock edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[widx] <= wdata;
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/i_mem_responder.sv
// Instruction memory responder: accepts the merged fetch request, waits LAT
// cycles on a stable word index and then presents the word for exactly one
// cycle. A preload write to the word being returned on the same edge is
// forwarded into iload.
module i_mem_responder
   import cpu_types_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic               CLK,
   input  logic               RST,
   i_mem_responder_if.slave   bus,
   output imem_state_t        dbg_state
);

   // Counter wide enough to hold LAT; one bit minimum so LAT=0 still elaborates.
   localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   imem_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] cap_idx;
   word_t            load_q;

   logic [IDX_W-1:0] req_idx;
   logic [IDX_W-1:0] pre_idx;
   logic [IDX_W-1:0] rd_idx;
   word_t            rd_data;
   word_t            fwd_data;
   logic             we;
   logic             hit;
   logic             unused_addr_bits;

   assign req_idx = bus.iaddr[IDX_W+IMEM_IDX_LSB-1:IMEM_IDX_LSB];
   assign pre_idx = bus.paddr[IDX_W+IMEM_IDX_LSB-1:IMEM_IDX_LSB];

   // Byte-lane bits and bits above the store size are deliberately ignored.
   assign unused_addr_bits = ^{bus.iaddr[IMEM_IDX_LSB-1:0], bus.iaddr[31:IDX_W+IMEM_IDX_LSB],
                               bus.paddr[IMEM_IDX_LSB-1:0], bus.paddr[31:IDX_W+IMEM_IDX_LSB]};

   // Reset wins over a preload write on the same edge.
   assign we = bus.pWEN & ~RST;

   // In IDLE the word is loaded straight from the incoming index (LAT=0);
   // otherwise it comes from the index captured at the start of the request.
   assign rd_idx = (state == IDLE) ? req_idx : cap_idx;

   // A write to the word being loaded on this edge must be visible in iload.
   assign fwd_data = (we && (pre_idx == rd_idx)) ? bus.pstore : rd_data;

   assign hit       = (state == READY) && (req_idx == cap_idx);
   assign bus.iwait = bus.iREN & ~hit;
   assign bus.iload = load_q;
   assign dbg_state = state;

   imem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (CLK),
      .we    (we),
      .widx  (pre_idx),
      .wdata (bus.pstore),
      .ridx  (rd_idx),
      .rdata (rd_data)
   );

   // Request FSM: capture, count down on a stable index, present for one cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         cap_idx <= '0;
         load_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.iREN) begin
                  cap_idx <= req_idx;
                  if (LAT == 0) begin
                     state  <= READY;
                     load_q <= fwd_data;
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_LOAD;
                  end
               end
            end
            BUSY: begin
               if (!bus.iREN) begin
                  state <= IDLE;
               end else if (req_idx != cap_idx) begin
                  // Requester moved to another word: start the wait over.
                  cap_idx <= req_idx;
                  cnt     <= CNT_LOAD;
               end else if (cnt == CNT_ONE) begin
                  state  <= READY;
                  load_q <= fwd_data;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            READY: begin
               // Always one cycle; a held request is re-served from IDLE.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i_mem_responder.sv
// Bench for i_mem_responder: three instances (LAT = 0, 2, 3) see identical
// stimulus. A request-age model predicts iwait, iload and state every cycle;
// directed literal checks pin the model to hand-derived waveforms.
module tb_i_mem_responder;
   import cpu_types_pkg::*;

   localparam int DEPTH = 1024;
   localparam int N     = 3;
   localparam int K_L0  = 0;
   localparam int K_L2  = 1;
   localparam int K_L3  = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- stimulus signals ----------------
   logic  ren;
   word_t addr;
   logic  wen;
   word_t paddr_v;
   word_t pstore_v;

   i_mem_responder_if bus0 ();
   i_mem_responder_if bus1 ();
   i_mem_responder_if bus2 ();

   assign bus0.iREN = ren;  assign bus0.iaddr = addr;
   assign bus0.pWEN = wen;  assign bus0.paddr = paddr_v;  assign bus0.pstore = pstore_v;
   assign bus1.iREN = ren;  assign bus1.iaddr = addr;
   assign bus1.pWEN = wen;  assign bus1.paddr = paddr_v;  assign bus1.pstore = pstore_v;
   assign bus2.iREN = ren;  assign bus2.iaddr = addr;
   assign bus2.pWEN = wen;  assign bus2.paddr = paddr_v;  assign bus2.pstore = pstore_v;

   imem_state_t st0, st1, st2;

   i_mem_responder #(.LAT(0), .DEPTH(DEPTH)) dut0 (.CLK(clk), .RST(rst), .bus(bus0), .dbg_state(st0));
   i_mem_responder #(.LAT(2), .DEPTH(DEPTH)) dut1 (.CLK(clk), .RST(rst), .bus(bus1), .dbg_state(st1));
   i_mem_responder #(.LAT(3), .DEPTH(DEPTH)) dut2 (.CLK(clk), .RST(rst), .bus(bus2), .dbg_state(st2));

   // ---------------- accessors ----------------
   function automatic int lat_of(input int k);
      case (k)
         0:       return 0;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic get_wait(input int k);
      case (k)
         0:       return bus0.iwait;
         1:       return bus1.iwait;
         default: return bus2.iwait;
      endcase
   endfunction

   function automatic word_t get_load(input int k);
      case (k)
         0:       return bus0.iload;
         1:       return bus1.iload;
         default: return bus2.iload;
      endcase
   endfunction

   function automatic imem_state_t get_state(input int k);
      case (k)
         0:       return st0;
         1:       return st1;
         default: return st2;
      endcase
   endfunction

   function automatic int idx_of(input word_t a);
      return int'((a >> 2) % DEPTH);
   endfunction

   // ---------------- scoreboard counters ----------------
   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // m_run[k] = number of cycles the current request has already been
   // presented (same word index, iREN held). The word is served in the cycle
   // after LAT+1 presented cycles; then the request ages out.
   word_t m_mem  [DEPTH];
   int    m_run  [N];
   int    m_idx  [N];
   word_t m_load [N];

   initial begin
      bit          served;
      logic        exp_wait;
      imem_state_t exp_st;
      for (int k = 0; k < N; k++) begin
         m_run[k]  = 0;
         m_idx[k]  = 0;
         m_load[k] = '0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            served   = ren && (m_run[k] == lat_of(k) + 1) && (idx_of(addr) == m_idx[k]);
            exp_wait = ren && !served;
            if (m_run[k] == 0)                  exp_st = IDLE;
            else if (m_run[k] == lat_of(k) + 1) exp_st = READY;
            else                                exp_st = BUSY;
            if (chk_en) begin
               check($sformatf("cyc_iwait_lat%0d", lat_of(k)), 32'(get_wait(k)), 32'(exp_wait));
               check($sformatf("cyc_iload_lat%0d", lat_of(k)), get_load(k), m_load[k]);
               check($sformatf("cyc_state_lat%0d", lat_of(k)), 32'(get_state(k)), 32'(exp_st));
            end
         end
         // Advance the model across the coming edge.
         for (int k = 0; k < N; k++) begin
            if (rst) begin
               m_run[k]  = 0;
               m_load[k] = '0;
            end else if (!ren || m_run[k] == lat_of(k) + 1) begin
               m_run[k] = 0;
            end else begin
               if (m_run[k] == 0 || idx_of(addr) != m_idx[k]) begin
                  m_run[k] = 1;
                  m_idx[k] = idx_of(addr);
               end else begin
                  m_run[k] = m_run[k] + 1;
               end
               if (m_run[k] == lat_of(k) + 1) begin
                  if (wen && idx_of(paddr_v) == m_idx[k]) m_load[k] = pstore_v;
                  else                                    m_load[k] = m_mem[m_idx[k]];
               end
            end
         end
         if (!rst && wen) m_mem[idx_of(paddr_v)] = pstore_v;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input word_t a, input word_t d);
      wen = 1'b1; paddr_v = a; pstore_v = d;
      tick();
      wen = 1'b0;
   endtask

   // Counts waiting cycles from the next negedge until iwait falls (bounded).
   task automatic count_wait(input int k, output int n);
      n = 0;
      forever begin
         @(negedge clk);
         if (get_wait(k) == 1'b0 || n >= 20) break;
         n++;
         tick();
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [4:0] seq0, seq2;
      word_t      l0, l2;
      int         n;

      ren = 1'b0; addr = '0; wen = 1'b0; paddr_v = '0; pstore_v = '0; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset state
      @(negedge clk);
      check("reset_iload", get_load(K_L2), 32'h0);
      check("reset_state", 32'(get_state(K_L2)), 32'(IDLE));
      check("reset_iwait", 32'(get_wait(K_L2)), 32'h0);
      tick();

      preload(32'h40,  32'h8C22_0004);
      preload(32'h100, 32'h1111_1111);
      preload(32'h104, 32'h2222_2222);
      preload(32'h0,   32'h0BAD_F00D);

      // Latency with a held request
      ren = 1'b1; addr = 32'h40;
      seq0 = '0; seq2 = '0; l0 = '0; l2 = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         seq0[c] = get_wait(K_L0);
         seq2[c] = get_wait(K_L2);
         if (c == 1) l0 = get_load(K_L0);
         if (c == 3) l2 = get_load(K_L2);
         tick();
      end
      check("lat2_iwait_seq", 32'(seq2), 32'h17);
      check("lat2_word",      l2,        32'h8C22_0004);
      check("lat0_iwait_seq", 32'(seq0), 32'h15);
      check("lat0_word",      l0,        32'h8C22_0004);
      ren = 1'b0; tick(); tick();

      // Address restart after two cycles
      ren = 1'b1; addr = 32'h100;
      tick(); tick();
      addr = 32'h104;
      count_wait(K_L3, n);
      check("restart_wait_cycles", 32'(n), 32'd4);
      check("restart_word", get_load(K_L3), 32'h2222_2222);
      tick();
      ren = 1'b0; tick(); tick();

      // Abort during BUSY, then a fresh request
      ren = 1'b1; addr = 32'h40;
      tick(); tick();
      ren = 1'b0;
      @(negedge clk);
      check("abort_iwait_now", 32'(get_wait(K_L3)), 32'h0);
      tick();
      @(negedge clk);
      check("abort_state_idle", 32'(get_state(K_L3)), 32'(IDLE));
      check("abort_iload_kept", get_load(K_L3), 32'h2222_2222);
      tick();
      ren = 1'b1; addr = 32'h40;
      count_wait(K_L3, n);
      check("abort_rewait_cycles", 32'(n), 32'd4);
      check("abort_rewait_word", get_load(K_L3), 32'h8C22_0004);
      tick();
      ren = 1'b0; tick(); tick();

      // Forwarding on the completing edge, aliased address
      ren = 1'b1; addr = 32'h1000;
      tick(); tick();
      wen = 1'b1; paddr_v = 32'h0; pstore_v = 32'hDEAD_BEEF;
      tick();
      wen = 1'b0;
      @(negedge clk);
      check("fwd_iwait", 32'(get_wait(K_L2)), 32'h0);
      check("fwd_word",  get_load(K_L2), 32'hDEAD_BEEF);
      tick();
      ren = 1'b0; tick(); tick();

      // Byte-lane bits ignored
      ren = 1'b1; addr = 32'h41;
      count_wait(K_L2, n);
      check("lowbits_wait_cycles", 32'(n), 32'd3);
      check("lowbits_word", get_load(K_L2), 32'h8C22_0004);
      tick();
      ren = 1'b0; tick(); tick();

      // Reset in the middle of BUSY with the request held
      ren = 1'b1; addr = 32'h100;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy_iload", get_load(K_L2), 32'h0);
      check("rst_busy_state", 32'(get_state(K_L2)), 32'(IDLE));
      check("rst_busy_iwait", 32'(get_wait(K_L2)), 32'h1);
      tick();
      // First post-reset waiting cycle already seen above; two more remain.
      count_wait(K_L2, n);
      check("rst_rewait_cycles", 32'(n), 32'd2);
      check("rst_retained_word", get_load(K_L2), 32'h1111_1111);
      tick();
      ren = 1'b0; tick(); tick();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Run-away guard
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish before 100000");
      $fatal(1);
   end

endmodule
